// File: rtl/fetch_queue_unit.sv
// Instruction fetch front end: PC, imem port, and a DEPTH-entry
// {pc, inst} queue feeding decode over a valid/ready handshake.
module fetch_queue_unit #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter bit PREDECODE_J = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic [ADDR_W-1:0]            imem_addr,
  input  logic [DATA_W-1:0]            imem_rdata,
  input  logic                         stall,
  input  logic                         redirect_valid,
  input  logic [ADDR_W-1:0]            redirect_addr,
  output logic                         inst_valid,
  input  logic                         inst_ready,
  output logic [DATA_W-1:0]            inst,
  output logic [ADDR_W-1:0]            inst_pc,
  output logic [$clog2(DEPTH+1)-1:0]   fetch_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_plus4, jmp_tgt;
  logic [PTR_W-1:0]  rd_q, rd_d;
  logic [PTR_W-1:0]  wr_q, wr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              push, pop, is_jmp;

  logic [ADDR_W-1:0] mem_pc_q  [DEPTH];
  logic [DATA_W-1:0] mem_ins_q [DEPTH];

  function automatic logic [PTR_W-1:0] inc(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    pc_plus4 = pc_q + ADDR_W'(4);
    // J/JAL keep the upper PC bits of the delay slot address
    jmp_tgt = pc_plus4;
    jmp_tgt[27:0] = {imem_rdata[25:0], 2'b00};
    is_jmp = PREDECODE_J &&
             (imem_rdata[31:26] == 6'd2 ||
              imem_rdata[31:26] == 6'd3);

    pop  = (cnt_q != '0) && inst_ready;
    push = !stall && !redirect_valid &&
           ((cnt_q < CNT_W'(DEPTH)) || pop);

    pc_d  = pc_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;

    if (redirect_valid) begin
      pc_d  = {redirect_addr[ADDR_W-1:2], 2'b00};
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        wr_d = inc(wr_q);
        pc_d = is_jmp ? jmp_tgt : pc_plus4;
      end
      if (pop) rd_d = inc(rd_q);
      if (push && !pop)
        cnt_d = cnt_q + CNT_W'(1);
      else if (pop && !push)
        cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_pc_q[wr_q]  <= pc_q;
      mem_ins_q[wr_q] <= imem_rdata;
    end
  end

  assign imem_addr   = pc_q;
  assign inst_valid  = (cnt_q != '0);
  assign inst        = mem_ins_q[rd_q];
  assign inst_pc     = mem_pc_q[rd_q];
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: queue-based reference model checked
// every cycle, plus directed literal checks on both predecode modes.
module tb_fetch_queue_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, redirect_valid, inst_ready;
  logic [31:0] redirect_addr;
  logic        jmp_on;

  logic [31:0] addr_a, rdata_a, inst_a, ipc_a;
  logic        valid_a;
  logic [2:0]  cnt_a;
  logic [31:0] addr_b, rdata_b, inst_b, ipc_b;
  logic        valid_b;
  logic [2:0]  cnt_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Simple program: opcode 8 everywhere, one J at 0x8 when enabled
  assign rdata_a = (jmp_on && addr_a == 32'h8) ? 32'h0800_0040
                   : {6'd8, addr_a[25:0]};
  assign rdata_b = (jmp_on && addr_b == 32'h8) ? 32'h0800_0040
                   : {6'd8, addr_b[25:0]};

  fetch_queue_unit #(.DEPTH(DEPTH), .PREDECODE_J(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(addr_a), .imem_rdata(rdata_a),
    .stall(stall), .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr),
    .inst_valid(valid_a), .inst_ready(inst_ready),
    .inst(inst_a), .inst_pc(ipc_a), .fetch_count(cnt_a)
  );

  fetch_queue_unit #(.DEPTH(DEPTH), .PREDECODE_J(1'b0)) u_nj (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(addr_b), .imem_rdata(rdata_b),
    .stall(stall), .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr),
    .inst_valid(valid_b), .inst_ready(inst_ready),
    .inst(inst_b), .inst_pc(ipc_b), .fetch_count(cnt_b)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (jmp_on && a == 32'h8) return 32'h0800_0040;
    return {6'd8, a[25:0]};
  endfunction

  // Reference model: a plain queue of fetched pairs
  logic [31:0] m_pc;
  logic [31:0] q_pc[$];
  logic [31:0] q_in[$];
  bit armed = 0;

  always @(posedge clk) begin
    logic [31:0] w, p4;
    bit do_pop;
    if (!rst_n) begin
      m_pc = 32'h0;
      q_pc.delete();
      q_in.delete();
      armed = 1;
    end else if (armed) begin
      do_pop = (q_pc.size() != 0) && inst_ready;
      if (redirect_valid) begin
        q_pc.delete();
        q_in.delete();
        m_pc = {redirect_addr[31:2], 2'b00};
      end else begin
        if (do_pop) begin
          void'(q_pc.pop_front());
          void'(q_in.pop_front());
        end
        if (!stall && q_pc.size() < DEPTH) begin
          w = mem_word(m_pc);
          q_pc.push_back(m_pc);
          q_in.push_back(w);
          p4 = m_pc + 32'd4;
          if (w[31:26] == 6'd2 || w[31:26] == 6'd3)
            m_pc = {p4[31:28], w[25:0], 2'b00};
          else
            m_pc = p4;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("m_addr", addr_a, m_pc);
      chk("m_valid", valid_a, q_pc.size() != 0);
      chk("m_count", cnt_a, q_pc.size());
      if (q_pc.size() != 0) begin
        chk("m_inst_pc", ipc_a, q_pc[0]);
        chk("m_inst", inst_a, q_in[0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_j [5];
  logic [31:0] exp_n [5];

  initial begin
    exp_j = '{32'h0, 32'h4, 32'h8, 32'h100, 32'h104};
    exp_n = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    rst_n = 0; stall = 0; redirect_valid = 0;
    redirect_addr = 0; inst_ready = 1; jmp_on = 0;
    tick(); tick();
    chk("rst_addr", addr_a, 32'h0);
    chk("rst_valid", valid_a, 1'b0);
    chk("rst_count", cnt_a, 3'd0);

    // streaming with ready high
    rst_n = 1;
    tick();
    chk("s0_valid", valid_a, 1'b1);
    chk("s0_pc", ipc_a, 32'h0);
    tick();
    chk("s1_pc", ipc_a, 32'h4);
    tick();
    chk("s2_pc", ipc_a, 32'h8);
    chk("s2_count", cnt_a, 3'd1);

    // fill to full
    rst_n = 0; tick();
    rst_n = 1; inst_ready = 0;
    repeat (4) tick();
    chk("full_count", cnt_a, 3'd4);
    chk("full_addr", addr_a, 32'h10);
    chk("full_head", ipc_a, 32'h0);
    tick();
    chk("hold_addr", addr_a, 32'h10);
    inst_ready = 1;
    tick();
    chk("fp_count", cnt_a, 3'd4);
    chk("fp_addr", addr_a, 32'h14);
    chk("fp_head", ipc_a, 32'h4);

    // redirect over stall while full
    inst_ready = 0; stall = 1;
    redirect_valid = 1; redirect_addr = 32'h203;
    tick();
    chk("rd_count", cnt_a, 3'd0);
    chk("rd_valid", valid_a, 1'b0);
    chk("rd_addr", addr_a, 32'h200);
    redirect_valid = 0; stall = 0;
    tick();
    chk("rd_head", ipc_a, 32'h200);
    chk("rd_valid2", valid_a, 1'b1);

    // fill, then drain under stall
    repeat (3) tick();
    chk("f2_count", cnt_a, 3'd4);
    stall = 1; inst_ready = 1;
    repeat (4) tick();
    chk("dr_count", cnt_a, 3'd0);
    chk("dr_valid", valid_a, 1'b0);
    chk("dr_addr", addr_a, 32'h210);
    tick();
    chk("dr_addr2", addr_a, 32'h210);
    stall = 0;
    tick();
    chk("res_head", ipc_a, 32'h210);

    // J predecode versus no predecode
    rst_n = 0; jmp_on = 1; tick();
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("j_pc", ipc_a, exp_j[i]);
      chk("nj_pc", ipc_b, exp_n[i]);
      chk("nj_valid", valid_b, 1'b1);
    end

    // PC wrap, then reset mid-stream
    jmp_on = 0;
    redirect_valid = 1; redirect_addr = 32'hFFFF_FFFC;
    tick();
    chk("w_addr", addr_a, 32'hFFFF_FFFC);
    redirect_valid = 0;
    tick();
    chk("w_next", addr_a, 32'h0);
    chk("w_head", ipc_a, 32'hFFFF_FFFC);
    inst_ready = 0;
    tick(); tick();
    rst_n = 0;
    tick();
    chk("mr_addr", addr_a, 32'h0);
    chk("mr_count", cnt_a, 3'd0);
    chk("mr_valid", valid_a, 1'b0);
    rst_n = 1;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
